// File: rtl/instr_encoder_loader.sv
// Packs decoded MIPS-subset instruction fields into 32-bit words and streams them
// into instruction memory at sequential byte addresses, up to DEPTH words.
module instr_encoder_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 256
) (
  input  logic        clk,
  input  logic        rstN,
  input  logic        clear,
  input  logic        inValid,
  output logic        inReady,
  input  logic [3:0]  opSel,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [15:0] imm,
  input  logic [25:0] jAddr,
  output logic        imValid,
  input  logic        imReady,
  output logic [31:0] imAddr,
  output logic [31:0] imData,
  output logic [15:0] wordCount,
  output logic        full,
  output logic        err
);

  localparam logic [3:0] OP_LW   = 4'd0;
  localparam logic [3:0] OP_SW   = 4'd1;
  localparam logic [3:0] OP_J    = 4'd2;
  localparam logic [3:0] OP_JR   = 4'd3;
  localparam logic [3:0] OP_JAL  = 4'd4;
  localparam logic [3:0] OP_BEQ  = 4'd5;
  localparam logic [3:0] OP_BNE  = 4'd6;
  localparam logic [3:0] OP_XORI = 4'd7;
  localparam logic [3:0] OP_ADDI = 4'd8;
  localparam logic [3:0] OP_ADD  = 4'd9;
  localparam logic [3:0] OP_SUB  = 4'd10;
  localparam logic [3:0] OP_SLT  = 4'd11;

  localparam logic [15:0] LP_DEPTH = 16'(DEPTH);
  localparam logic [15:0] LP_LAST  = 16'(DEPTH - 1);

  logic        r_im_valid;
  logic [31:0] r_im_addr;
  logic [31:0] r_im_data;
  logic [15:0] r_word_count;
  logic        r_full;
  logic        r_err;

  logic        w_legal;
  logic [31:0] w_word;
  logic        w_slot_free;
  logic        w_accept;
  logic        w_xfer;

  always_comb begin
    w_legal = 1'b1;
    w_word  = '0;
    case (opSel)
      OP_LW:   w_word = {6'h23, rs, rt, imm};
      OP_SW:   w_word = {6'h2B, rs, rt, imm};
      OP_J:    w_word = {6'h02, jAddr};
      OP_JR:   w_word = {6'h00, rs, 15'd0, 6'h08};
      OP_JAL:  w_word = {6'h03, jAddr};
      OP_BEQ:  w_word = {6'h04, rs, rt, imm};
      OP_BNE:  w_word = {6'h05, rs, rt, imm};
      OP_XORI: w_word = {6'h0E, rs, rt, imm};
      OP_ADDI: w_word = {6'h08, rs, rt, imm};
      OP_ADD:  w_word = {6'h00, rs, rt, rd, 5'd0, 6'h20};
      OP_SUB:  w_word = {6'h00, rs, rt, rd, 5'd0, 6'h22};
      OP_SLT:  w_word = {6'h00, rs, rt, rd, 5'd0, 6'h2A};
      default: w_legal = 1'b0;
    endcase
  end

  // The DEPTH-th word in flight must not be refilled, otherwise a (DEPTH+1)-th
  // word would already be pending when full rises and could still be written.
  assign w_slot_free = !r_im_valid || (imReady && (r_word_count != LP_LAST));
  assign inReady     = !r_full && w_slot_free;
  assign w_accept    = inValid && inReady;
  assign w_xfer      = r_im_valid && imReady;

  always_ff @(posedge clk) begin
    if (!rstN || clear) begin
      r_im_valid   <= 1'b0;
      r_im_data    <= '0;
      r_im_addr    <= BASE_ADDR;
      r_word_count <= '0;
      r_full       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      if (w_xfer) begin
        r_im_addr    <= r_im_addr + 32'd4;
        r_word_count <= r_word_count + 16'd1;
        r_full       <= (r_word_count + 16'd1) == LP_DEPTH;
      end
      if (w_accept && w_legal) begin
        r_im_valid <= 1'b1;
        r_im_data  <= w_word;
      end else begin
        if (w_accept) r_err <= 1'b1;
        if (w_xfer)   r_im_valid <= 1'b0;
      end
    end
  end

  assign imValid   = r_im_valid;
  assign imAddr    = r_im_addr;
  assign imData    = r_im_data;
  assign wordCount = r_word_count;
  assign full      = r_full;
  assign err       = r_err;

endmodule
